fusion_pixel_packer: RTL and testbench

- Inverse of the Fusion converter's serializer. Takes 4bpp pixel pairs in display order, on the same ad/bd lanes that feed the LSPC line buffers, and rebuilds 32-bit planar C-ROM words.
- Each word is 8 pixels, 4 bitplanes, one byte per plane. The h (flip) and even (lane swap) rules match the converter's output side, so a packed word replayed through the converter gives back the same pixel stream.
- Used by the cart-image builder and the converter's loopback bench; sits between a pixel source and C-ROM flash write logic.

---
 rtl/fusion_pixel_packer_if.sv | 43 ++++
 rtl/fusion_pixel_packer.sv | 127 ++++++++++++
 tb/tb_fusion_pixel_packer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fusion_pixel_packer_if.sv
// Pixel-pair in / packed-word out bus for fusion_pixel_packer.
// master = pixel source and word consumer, slave = packer.
interface fusion_pixel_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ad;
    logic [3:0]  bd;
    logic        even;
    logic        h;
    logic        sof;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        c_opaque;

    modport master (
        output in_valid,
        output ad,
        output bd,
        output even,
        output h,
        output sof,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  c,
        input  c_opaque
    );

    modport slave (
        input  in_valid,
        input  ad,
        input  bd,
        input  even,
        input  h,
        input  sof,
        input  out_ready,
        output in_ready,
        output out_valid,
        output c,
        output c_opaque
    );
endinterface

// File: rtl/fusion_pixel_packer.sv
// fusion_pixel_packer: rebuilds 32-bit planar C-ROM words
// from 4bpp ad/bd pixel pairs in display order.
module fusion_pixel_packer #(
    parameter bit FLIP_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fusion_pixel_packer_if.slave bus,
    output logic                 resync_err,
    output logic [CNT_W-1:0]     word_cnt
);

    logic [1:0]  pair_cnt;
    logic [31:0] acc;
    logic        h_l;
    logic        even_l;
    logic        out_valid_q;
    logic [31:0] c_q;
    logic        c_opaque_q;

    logic        in_ready;
    logic        take;
    logic        start;
    logic        restart;
    logic        done;
    logic        drain;
    logic        h_eff;
    logic        even_eff;
    logic [1:0]  slot;
    logic [3:0]  px_first;
    logic [3:0]  px_second;
    logic [2:0]  pos_first;
    logic [2:0]  pos_second;
    logic [31:0] acc_base;
    logic [31:0] acc_next;

    // Only the last pair of a word needs the output register free.
    assign in_ready = !(pair_cnt == 2'd3 && out_valid_q
                        && !bus.out_ready);
    assign take     = bus.in_valid && in_ready;
    assign start    = (pair_cnt == 2'd0) || bus.sof;
    assign restart  = take && bus.sof && (pair_cnt != 2'd0);
    assign done     = take && !start && (pair_cnt == 2'd3);
    assign drain    = out_valid_q && bus.out_ready;

    // A word's first pair supplies h/even; later pairs reuse the latch.
    assign h_eff    = start ? (bus.h && FLIP_EN) : h_l;
    assign even_eff = start ? bus.even : even_l;
    assign slot     = start ? 2'd0 : pair_cnt;

    // Lane order and pixel positions for the pair being taken.
    always_comb begin
        px_first   = even_eff ? bus.bd : bus.ad;
        px_second  = even_eff ? bus.ad : bus.bd;
        pos_first  = h_eff ? (3'd7 - {slot, 1'b0})
                           : {slot, 1'b0};
        pos_second = h_eff ? (3'd6 - {slot, 1'b0})
                           : {slot, 1'b1};
    end

    // Merge the pair into every plane; a new word starts from zero.
    always_comb begin
        acc_base = start ? 32'h0 : acc;
        acc_next = acc_base;
        for (int p = 0; p < 4; p++) begin
            acc_next[{2'(p), pos_first}]  = px_first[p];
            acc_next[{2'(p), pos_second}] = px_second[p];
        end
    end

    // Word assembly state: pair counter, accumulator, latched flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pair_cnt <= 2'd0;
            acc      <= 32'h0;
            h_l      <= 1'b0;
            even_l   <= 1'b0;
        end else if (take) begin
            if (start) begin
                h_l    <= h_eff;
                even_l <= even_eff;
            end
            if (done) begin
                pair_cnt <= 2'd0;
                acc      <= 32'h0;
            end else begin
                pair_cnt <= slot + 2'd1;
                acc      <= acc_next;
            end
        end
    end

    // Single-entry output buffer; a finishing word may replace a draining one.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            c_q         <= 32'h0;
            c_opaque_q  <= 1'b0;
        end else if (done) begin
            out_valid_q <= 1'b1;
            c_q         <= acc_next;
            c_opaque_q  <= |acc_next;
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

    // Emitted-word counter and resync pulse for a discarded partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt   <= '0;
            resync_err <= 1'b0;
        end else begin
            resync_err <= restart;
            if (drain) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.c_opaque  = c_opaque_q;

endmodule

// File: tb/tb_fusion_pixel_packer.sv
// tb_fusion_pixel_packer: directed vectors with a pixel-level
// reference model checked every cycle on three packer variants.
module tb_fusion_pixel_packer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] ad;
    logic [3:0] bd;
    logic       even;
    logic       h;
    logic       sof;
    logic       out_ready;

    logic        err_a;
    logic        err_w;
    logic        err_n;
    logic [15:0] wc_a;
    logic [1:0]  wc_w;
    logic [15:0] wc_n;

    int n_vec;
    int n_err;
    int m_taken;
    bit chk_en;

    fusion_pixel_packer_if if_a ();
    fusion_pixel_packer_if if_w ();
    fusion_pixel_packer_if if_n ();

    assign {if_a.in_valid, if_a.ad, if_a.bd, if_a.even, if_a.h, if_a.sof,
            if_a.out_ready} = {in_valid, ad, bd, even, h, sof, out_ready};
    assign {if_w.in_valid, if_w.ad, if_w.bd, if_w.even, if_w.h, if_w.sof,
            if_w.out_ready} = {in_valid, ad, bd, even, h, sof, out_ready};
    assign {if_n.in_valid, if_n.ad, if_n.bd, if_n.even, if_n.h, if_n.sof,
            if_n.out_ready} = {in_valid, ad, bd, even, h, sof, out_ready};

    fusion_pixel_packer u_a (
        .clk        (clk),
        .reset      (reset),
        .bus        (if_a),
        .resync_err (err_a),
        .word_cnt   (wc_a)
    );

    fusion_pixel_packer #(.CNT_W(2)) u_w (
        .clk        (clk),
        .reset      (reset),
        .bus        (if_w),
        .resync_err (err_w),
        .word_cnt   (wc_w)
    );

    fusion_pixel_packer #(.FLIP_EN(1'b0)) u_n (
        .clk        (clk),
        .reset      (reset),
        .bus        (if_n),
        .resync_err (err_n),
        .word_cnt   (wc_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0][3:0] pix;
        int              pc;
        bit              hl;
        bit              el;
        bit              ov;
        logic [31:0]     c;
        bit              err;
        int              wcnt;
    } mstate_t;

    mstate_t ms_a;
    mstate_t ms_w;
    mstate_t ms_n;

    function automatic logic [31:0] pack_word(logic [7:0][3:0] pix);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 8; k++)
            for (int p = 0; p < 4; p++)
                w[8*p+k] = pix[k][p];
        return w;
    endfunction

    function automatic mstate_t reset_state();
        mstate_t r;
        r.pix  = '0;
        r.pc   = 0;
        r.hl   = 0;
        r.el   = 0;
        r.ov   = 0;
        r.c    = '0;
        r.err  = 0;
        r.wcnt = 0;
        return r;
    endfunction

    function automatic bit model_rdy(mstate_t s, logic ordy);
        return !(s.pc == 3 && s.ov && !ordy);
    endfunction

    function automatic mstate_t step(mstate_t s, bit flip, int wrap);
        mstate_t n;
        int j;
        logic [3:0] f;
        logic [3:0] sc;
        if (reset) return reset_state();
        n = s;
        n.err = 0;
        if (s.ov && out_ready) begin
            n.ov = 0;
            n.wcnt = (s.wcnt + 1) % wrap;
        end
        if (in_valid && model_rdy(s, out_ready)) begin
            if (sof || s.pc == 0) begin
                n.err = (s.pc != 0);
                n.pix = '0;
                n.hl = h && flip;
                n.el = even;
                j = 0;
            end else begin
                j = s.pc;
            end
            f  = n.el ? bd : ad;
            sc = n.el ? ad : bd;
            if (n.hl) begin
                n.pix[7-2*j] = f;
                n.pix[6-2*j] = sc;
            end else begin
                n.pix[2*j]   = f;
                n.pix[2*j+1] = sc;
            end
            if (j == 3) begin
                n.c = pack_word(n.pix);
                n.ov = 1;
                n.pix = '0;
                n.pc = 0;
            end else begin
                n.pc = j + 1;
            end
        end
        return n;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!reset && in_valid && model_rdy(ms_a, out_ready))
                m_taken++;
            ms_a = step(ms_a, 1'b1, 65536);
            ms_w = step(ms_w, 1'b1, 4);
            ms_n = step(ms_n, 1'b0, 65536);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mstate_t s,
                            input logic rdy, input logic ov,
                            input logic [31:0] c, input logic op,
                            input logic err, input logic [31:0] wc);
        chk({tag, ".in_ready"}, 32'(rdy), 32'(model_rdy(s, out_ready)));
        chk({tag, ".out_valid"}, 32'(ov), 32'(s.ov));
        chk({tag, ".resync_err"}, 32'(err), 32'(s.err));
        chk({tag, ".word_cnt"}, wc, 32'(s.wcnt));
        if (s.ov) begin
            chk({tag, ".c"}, c, s.c);
            chk({tag, ".c_opaque"}, 32'(op), 32'(s.c != 32'h0));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp_inst("a", ms_a, if_a.in_ready, if_a.out_valid,
                         if_a.c, if_a.c_opaque, err_a, 32'(wc_a));
                cmp_inst("w", ms_w, if_w.in_ready, if_w.out_valid,
                         if_w.c, if_w.c_opaque, err_w, 32'(wc_w));
                cmp_inst("n", ms_n, if_n.in_ready, if_n.out_valid,
                         if_n.c, if_n.c_opaque, err_n, 32'(wc_n));
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic e, input logic hh, input logic s);
        int t0;
        t0 = m_taken;
        in_valid = 1'b1;
        ad = a;
        bd = b;
        even = e;
        h = hh;
        sof = s;
        for (int i = 0; i < 20 && m_taken == t0; i++) begin
            @(posedge clk);
            #1;
        end
        if (m_taken == t0) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no accept, expected accept within 20 cycles");
        end
        in_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic send_ref(input logic e, input logic hh);
        if (e) begin
            send(4'd2, 4'd1, e, hh, 1'b1);
            send(4'd4, 4'd3, e, hh, 1'b0);
            send(4'd6, 4'd5, e, hh, 1'b0);
            send(4'd8, 4'd7, e, hh, 1'b0);
        end else begin
            send(4'd1, 4'd2, e, hh, 1'b1);
            send(4'd3, 4'd4, e, hh, 1'b0);
            send(4'd5, 4'd6, e, hh, 1'b0);
            send(4'd7, 4'd8, e, hh, 1'b0);
        end
    endtask

    task automatic word_out(input string nm, input logic [31:0] exp);
        chk({nm, ".c"}, if_a.c, exp);
        chk({nm, ".out_valid"}, 32'(if_a.out_valid), 32'd1);
        chk({nm, ".c_opaque"}, 32'(if_a.c_opaque), 32'(exp != 32'h0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        m_taken = 0;
        chk_en = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        ad = 4'd0;
        bd = 4'd0;
        even = 1'b0;
        h = 1'b0;
        sof = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1;

        chk("rst.out_valid", 32'(if_a.out_valid), 32'd0);
        chk("rst.c", if_a.c, 32'h0);
        chk("rst.word_cnt", 32'(wc_a), 32'd0);
        chk("rst.in_ready", 32'(if_a.in_ready), 32'd1);

        send_ref(1'b0, 1'b0);
        word_out("A", 32'h80786655);
        chk("A.word_cnt", 32'(wc_a), 32'd1);

        send_ref(1'b1, 1'b0);
        word_out("B", 32'h80786655);

        send(4'd8, 4'd7, 1'b0, 1'b1, 1'b1);
        send(4'd6, 4'd5, 1'b0, 1'b1, 1'b0);
        send(4'd4, 4'd3, 1'b0, 1'b1, 1'b0);
        send(4'd2, 4'd1, 1'b0, 1'b1, 1'b0);
        chk("C.noflip.c", if_n.c, 32'h011E66AA);
        word_out("C", 32'h80786655);

        for (int i = 0; i < 4; i++)
            send(4'd0, 4'd0, 1'b0, 1'b0, i == 0);
        word_out("D", 32'h0);

        out_ready = 1'b0;
        send_ref(1'b0, 1'b0);
        chk("E.c", if_a.c, 32'h80786655);
        chk("E.out_valid", 32'(if_a.out_valid), 32'd1);
        send(4'd15, 4'd15, 1'b0, 1'b0, 1'b1);
        send(4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
        send(4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        ad = 4'd15;
        bd = 4'd15;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("F.stall_in_ready", 32'(if_a.in_ready), 32'd0);
        chk("F.stall_c", if_a.c, 32'h80786655);
        out_ready = 1'b1;
        send(4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
        chk("F.c", if_a.c, 32'hFFFFFFFF);
        chk("F.out_valid", 32'(if_a.out_valid), 32'd1);
        chk("F.word_cnt", 32'(wc_a), 32'd5);
        chk("F.wrap_cnt", 32'(wc_w), 32'd1);
        @(posedge clk);
        #1;

        send(4'd0, 4'd1, 1'b1, 1'b1, 1'b1);
        send(4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
        send(4'd4, 4'd5, 1'b1, 1'b1, 1'b0);
        send(4'd6, 4'd7, 1'b1, 1'b1, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        send(4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
        send(4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
        send(4'd1, 4'd2, 1'b0, 1'b0, 1'b1);
        chk("S.resync_err", 32'(err_a), 32'd1);
        send(4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
        send(4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
        send(4'd7, 4'd8, 1'b0, 1'b0, 1'b0);
        word_out("S", 32'h80786655);

        out_ready = 1'b0;
        send_ref(1'b0, 1'b0);
        send(4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
        send(4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("R.out_valid", 32'(if_a.out_valid), 32'd0);
        chk("R.c", if_a.c, 32'h0);
        chk("R.c_opaque", 32'(if_a.c_opaque), 32'd0);
        chk("R.resync_err", 32'(err_a), 32'd0);
        chk("R.word_cnt", 32'(wc_a), 32'd0);
        chk("R.in_ready", 32'(if_a.in_ready), 32'd1);
        out_ready = 1'b1;
        send_ref(1'b0, 1'b0);
        word_out("R", 32'h80786655);
        chk("R.word_cnt_after", 32'(wc_a), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
